bcd_to_binary_seq: RTL

Sequential BCD-to-binary converter: the decode direction of the binary-to-BCD path feeding the seven-segment displays. It accepts a packed 10-digit BCD word, such as an operand keyed in on board switches or a value read back from a display buffer, and produces the 32-bit unsigned binary value for the RISC-V datapath. It uses one multiply-by-10-and-add step per digit, with digit-validity and 32-bit overflow checking and a start/done handshake.

---
 rtl/bcd_to_binary_seq_if.sv | 22 ++
 rtl/bcd_to_binary_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - start/done handshake and result bus for the BCD-to-binary converter
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [31:0]           bin_out;
    logic                  err_digit;
    logic                  overflow;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err_digit, overflow
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err_digit, overflow
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter, one multiply-by-10-and-add per digit
module bcd_to_binary_seq #(
    parameter int DIGITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_binary_seq_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    sr_q;
    logic [35:0]     acc_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            ovf_q;

    logic            busy_q;
    logic            done_q;
    logic [31:0]     bin_q;
    logic            err_out_q;
    logic            ovf_out_q;

    logic [3:0]      nib;
    logic [3:0]      digit_d;
    logic [35:0]     acc_d;
    logic            err_d;
    logic            ovf_d;

    // One conversion step on the most significant remaining nibble; acc freezes once overflowed
    always_comb begin
        nib     = sr_q[W-1 -: 4];
        digit_d = nib;
        err_d   = err_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (nib > 4'd9) begin
            err_d   = 1'b1;
            digit_d = 4'd0;
        end
        if (!ovf_q) begin
            // acc < 2^32 here, so acc*10+9 still fits in 36 bits
            acc_d = (acc_q << 3) + (acc_q << 1) + {32'd0, digit_d};
            if (acc_d > 36'h0_FFFF_FFFF) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= '0;
            err_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sr_q    <= bus.bcd_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q <= acc_d;
                    err_q <= err_d;
                    ovf_q <= ovf_d;
                    sr_q  <= sr_q << 4;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // A bad digit makes the value meaningless, so it wins over saturation
                    if (err_q) begin
                        bin_q <= '0;
                    end else if (ovf_q) begin
                        bin_q <= 32'hFFFF_FFFF;
                    end else begin
                        bin_q <= acc_q[31:0];
                    end
                    err_out_q <= err_q;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bin_out   = bin_q;
    assign bus.err_digit = err_out_q;
    assign bus.overflow  = ovf_out_q;
endmodule
